stochastic_adc_ti_array: RTL and testbench

Parametrised, synthesizable successor to the single-slice behavioural ADC model, for CPU-vs-emulation comparison runs. It takes a stream of signed digitised input samples and distributes them round-robin over `Nch` time-interleaved slices. Each sample is quantised to sign-magnitude with a per-slice offset/gain calibration and clamping. Completed frames are presented as one wide parallel word with a clip count. The block sits between the channel/stimulus model and the DSP front end.

---
 rtl/stochastic_adc_ti_array.sv | 197 +++++++++++++++++++
 tb/tb_stochastic_adc_ti_array.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stochastic_adc_ti_array.sv
// Time-interleaved stochastic ADC array.
// Signed input samples are dealt round-robin to Nch slices. Each slice applies
// its own offset/gain calibration and quantises to sign-magnitude with clamping.
// A completed frame of Nch slices is presented as one wide word plus a clip count.
module stochastic_adc_ti_array #(
  parameter int Nch    = 16,
  parameter int Nin    = 12,
  parameter int Nadc   = 8,
  parameter int Ngain  = 8,
  parameter int Nshift = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en_sync_in,
  output logic                    en_sync_out,
  input  logic [Nch-1:0]          en_slice,
  input  logic                    vin_valid,
  input  logic signed [Nin-1:0]   vin,
  input  logic                    cal_we,
  input  logic [$clog2(Nch)-1:0]  cal_addr,
  input  logic signed [Nin-1:0]   cal_ofs,
  input  logic [Ngain-1:0]        cal_gain,
  output logic                    out_valid,
  output logic [Nch-1:0]          sign_out,
  output logic [Nch*Nadc-1:0]     adder_out,
  output logic [$clog2(Nch):0]    clip_cnt
);

  localparam int PW  = $clog2(Nch);
  localparam int CW  = PW + 1;
  localparam int DW  = Nin + 1;
  localparam int PRW = DW + Ngain;
  localparam int SH  = Ngain - 1 + Nshift;
  localparam int MW  = Nadc - 1;
  localparam logic [PRW-1:0]   FULL_SCALE = {{(PRW-MW){1'b0}}, {MW{1'b1}}};
  localparam logic [Ngain-1:0] GAIN_UNITY = Ngain'(1) << (Ngain - 1);
  localparam logic [PW-1:0]    LAST_SLICE = PW'(Nch - 1);

  // Magnitude exceeds the representable full scale.
  function automatic logic is_clip(input logic [PRW-1:0] m);
    return m > FULL_SCALE;
  endfunction

  // Clamp a full-width magnitude to the Nadc-bit field (top bit always 0).
  function automatic logic [Nadc-1:0] sat_mag(input logic [PRW-1:0] m);
    logic [PRW-1:0] c;
    c = is_clip(m) ? FULL_SCALE : m;
    return {1'b0, c[MW-1:0]};
  endfunction

  logic                  en_q;
  logic [PW-1:0]         ph;
  logic signed [Nin-1:0] ofs  [Nch];
  logic [Ngain-1:0]      gain [Nch];

  logic signed [Nin-1:0] vin_p1;
  logic [PW-1:0]         ph_p1;
  logic                  vld_p1;

  logic                  sign_p2;
  logic [Nadc-1:0]       mag_p2;
  logic                  clip_p2;
  logic [PW-1:0]         slice_p2;
  logic                  vld_p2;

  logic [Nch-1:0]        sign_buf;
  logic [Nch*Nadc-1:0]   mag_buf;
  logic [CW-1:0]         clip_acc;

  logic signed [DW-1:0]  d_p1;
  logic [DW-1:0]         abs_p1;
  logic [PRW-1:0]        prod_p1;
  logic [PRW-1:0]        m_p1;
  logic [Nch-1:0]        frame_sign;
  logic [Nch*Nadc-1:0]   frame_mag;
  logic [CW-1:0]         clip_sum;

  assign en_sync_out = en_q;

  // Enable alignment register and round-robin phase counter (held at 0 while disabled).
  always_ff @(posedge clk_in) begin
    if (rst) begin
      en_q <= 1'b0;
      ph   <= '0;
    end else begin
      en_q <= en_sync_in;
      if (!en_q)
        ph <= '0;
      else if (vin_valid)
        ph <= ph + PW'(1);
    end
  end

  // Per-slice calibration table; accepted regardless of enable.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < Nch; i++) begin
        ofs[i]  <= '0;
        gain[i] <= GAIN_UNITY;
      end
    end else if (cal_we) begin
      ofs[cal_addr]  <= cal_ofs;
      gain[cal_addr] <= cal_gain;
    end
  end

  // ---- stage 1: capture sample, slice index and accept flag ----
  // Input capture register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      vin_p1 <= '0;
      ph_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vin_p1 <= vin;
      ph_p1  <= ph;
      vld_p1 <= vin_valid & en_q;
    end
  end

  // Offset removal and gain at full width; calibration is read before any same-edge write lands.
  always_comb begin
    d_p1    = DW'(vin_p1) - DW'(ofs[ph_p1]);
    abs_p1  = d_p1[DW-1] ? DW'(-d_p1) : DW'(d_p1);
    prod_p1 = PRW'(abs_p1) * PRW'(gain[ph_p1]);
    m_p1    = prod_p1 >> SH;
  end

  // ---- stage 2: quantised sign-magnitude result for one slice ----
  // Quantiser register; disabled slices report sign 0, magnitude 0, no clip.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sign_p2  <= 1'b0;
      mag_p2   <= '0;
      clip_p2  <= 1'b0;
      slice_p2 <= '0;
      vld_p2   <= 1'b0;
    end else begin
      slice_p2 <= ph_p1;
      vld_p2   <= vld_p1 & en_q;
      if (en_slice[ph_p1]) begin
        sign_p2 <= ~d_p1[DW-1];
        mag_p2  <= sat_mag(m_p1);
        clip_p2 <= is_clip(m_p1);
      end else begin
        sign_p2 <= 1'b0;
        mag_p2  <= '0;
        clip_p2 <= 1'b0;
      end
    end
  end

  // Frame buffer as it looks with the current stage-2 result merged in.
  always_comb begin
    frame_sign = sign_buf;
    frame_mag  = mag_buf;
    if (vld_p2) begin
      frame_sign[slice_p2]              = sign_p2;
      frame_mag[slice_p2*Nadc +: Nadc]  = mag_p2;
    end
    clip_sum = clip_acc + CW'(clip_p2);
  end

  // ---- stage 3: frame assembly and output presentation ----
  // Buffer update, clip accumulation and frame hand-off on the last slice.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sign_buf  <= '0;
      mag_buf   <= '0;
      clip_acc  <= '0;
      out_valid <= 1'b0;
      sign_out  <= '0;
      adder_out <= '0;
      clip_cnt  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!en_q) begin
        sign_buf <= '0;
        mag_buf  <= '0;
        clip_acc <= '0;
      end else if (vld_p2) begin
        sign_buf <= frame_sign;
        mag_buf  <= frame_mag;
        if (slice_p2 == LAST_SLICE) begin
          sign_out  <= frame_sign;
          adder_out <= frame_mag;
          clip_cnt  <= clip_sum;
          out_valid <= 1'b1;
          clip_acc  <= '0;
        end else begin
          clip_acc <= clip_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_stochastic_adc_ti_array.sv
// Directed bench for stochastic_adc_ti_array with hand-computed frames.
module tb_stochastic_adc_ti_array;

  localparam int NCH = 16;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              en_sync_in;
  logic              en_sync_out;
  logic [NCH-1:0]    en_slice;
  logic              vin_valid;
  logic signed [11:0] vin;
  logic              cal_we;
  logic [3:0]        cal_addr;
  logic signed [11:0] cal_ofs;
  logic [7:0]        cal_gain;
  logic              out_valid;
  logic [NCH-1:0]    sign_out;
  logic [NCH*8-1:0]  adder_out;
  logic [4:0]        clip_cnt;

  stochastic_adc_ti_array dut (
    .clk_in(clk_in), .rst(rst), .en_sync_in(en_sync_in), .en_sync_out(en_sync_out),
    .en_slice(en_slice), .vin_valid(vin_valid), .vin(vin), .cal_we(cal_we),
    .cal_addr(cal_addr), .cal_ofs(cal_ofs), .cal_gain(cal_gain), .out_valid(out_valid),
    .sign_out(sign_out), .adder_out(adder_out), .clip_cnt(clip_cnt)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulse_cyc[$];
  logic [NCH-1:0]   cap_sign;
  logic [NCH*8-1:0] cap_mag;
  logic [4:0]       cap_clip;

  int vals[NCH];
  int exp_sg[NCH];
  int exp_mg[NCH];

  // Frame monitor, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (out_valid) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      cap_sign = sign_out;
      cap_mag  = adder_out;
      cap_clip = clip_cnt;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present vals[0..n-1]; optional idle cycle after each sample; cal write rides with sample cal_at.
  task automatic send_frame(input int n, input int gap, input int cal_at, output int end_cyc);
    for (int k = 0; k < n; k++) begin
      vin       = 12'(vals[k]);
      vin_valid = 1'b1;
      cal_we    = (k == cal_at);
      tick();
      end_cyc   = cyc;
      cal_we    = 1'b0;
      if (gap != 0) begin
        vin_valid = 1'b0;
        tick();
      end
    end
  endtask

  task automatic wait_pulse(input int target);
    int n = 0;
    while (pulses < target && n < 40) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    chk("pulse_count", pulses, target);
  endtask

  task automatic check_frame(input string tag, input int clip_exp);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("%s_sign%0d", tag, i), cap_sign[i], exp_sg[i]);
      chk($sformatf("%s_mag%0d", tag, i), cap_mag[i*8 +: 8], exp_mg[i]);
    end
    chk($sformatf("%s_clip", tag), cap_clip, clip_exp);
  endtask

  int e1, e2, p0;

  initial begin
    rst = 1'b1; en_sync_in = 1'b0; en_slice = '1; vin_valid = 1'b0; vin = '0;
    cal_we = 1'b0; cal_addr = '0; cal_ofs = '0; cal_gain = '0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      en_sync_in = 1'($urandom); vin_valid = 1'($urandom); vin = 12'($urandom);
      en_slice = 16'($urandom); cal_we = 1'($urandom); cal_addr = 4'($urandom);
      cal_ofs = 12'($urandom); cal_gain = 8'($urandom);
      tick();
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_en_sync_out", en_sync_out, 0);
    chk("rst_sign", sign_out, 0);
    chk("rst_adder_lo", adder_out[63:0], 0);
    chk("rst_adder_hi", adder_out[127:64], 0);
    chk("rst_clip", clip_cnt, 0);
    rst = 1'b0; en_sync_in = 1'b0; cal_we = 1'b0; en_slice = '1;
    for (int i = 0; i < 50; i++) begin
      vin_valid = 1'($urandom); vin = 12'($urandom);
      tick();
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_sign", sign_out, 0);
    chk("idle_en_sync_out", en_sync_out, 0);

    // Frame ordering: vin = 16k, two frames back to back.
    vin_valid = 1'b0; en_sync_in = 1'b1;
    tick();
    chk("en_sync_out_delay", en_sync_out, 1);
    for (int k = 0; k < NCH; k++) begin
      vals[k] = 16 * k; exp_sg[k] = 1; exp_mg[k] = k;
    end
    send_frame(NCH, 0, -1, e1);
    send_frame(NCH, 0, -1, e2);
    vin_valid = 1'b0;
    wait_pulse(2);
    if (pulse_cyc.size() >= 2) begin
      chk("latency", pulse_cyc[0], e1 + 2);
      chk("period16", pulse_cyc[1] - pulse_cyc[0], 16);
    end
    check_frame("order", 0);

    // Sign and clamp boundaries.
    for (int k = 0; k < NCH; k++) begin
      vals[k] = 0; exp_sg[k] = 1; exp_mg[k] = 0;
    end
    vals[3] = -160;  exp_sg[3] = 0; exp_mg[3] = 10;
    vals[5] = 2047;  exp_sg[5] = 1; exp_mg[5] = 127;
    vals[6] = -2048; exp_sg[6] = 0; exp_mg[6] = 127;
    send_frame(NCH, 0, -1, e1);
    vin_valid = 1'b0;
    wait_pulse(3);
    check_frame("clamp", 1);

    // Calibration write landing on the same edge as the slice-2 computation.
    for (int k = 0; k < NCH; k++) begin
      vals[k] = 0; exp_sg[k] = 1; exp_mg[k] = 0;
    end
    vals[2] = 352; exp_mg[2] = 22;
    cal_addr = 4'd2; cal_ofs = 12'sd32; cal_gain = 8'd64;
    send_frame(NCH, 0, 3, e1);
    vin_valid = 1'b0;
    wait_pulse(4);
    check_frame("cal_old", 0);
    exp_mg[2] = 10;
    send_frame(NCH, 0, -1, e1);
    vin_valid = 1'b0;
    wait_pulse(5);
    check_frame("cal_new", 0);

    // Reset mid-frame restores outputs and default calibration.
    send_frame(6, 0, -1, e1);
    rst = 1'b1; vin_valid = 1'b0;
    tick();
    chk("midrst_sign", sign_out, 0);
    chk("midrst_en_sync_out", en_sync_out, 0);
    rst = 1'b0;
    tick();
    exp_mg[2] = 22;
    send_frame(NCH, 0, -1, e1);
    vin_valid = 1'b0;
    wait_pulse(6);
    check_frame("midrst", 0);

    // Gapped samples with slice 7 disabled.
    en_slice = 16'hFF7F;
    for (int k = 0; k < NCH; k++) begin
      vals[k] = 16 * k; exp_sg[k] = 1; exp_mg[k] = k;
    end
    exp_sg[7] = 0; exp_mg[7] = 0;
    send_frame(NCH, 1, -1, e1);
    send_frame(NCH, 1, -1, e2);
    wait_pulse(8);
    if (pulse_cyc.size() >= 8)
      chk("period32", pulse_cyc[7] - pulse_cyc[6], 32);
    check_frame("gap", 0);

    // Abort after slice 9, restore 5 cycles later.
    en_slice = '1;
    p0 = pulses;
    send_frame(10, 0, -1, e1);
    en_sync_in = 1'b0; vin = 12'sd100;
    repeat (5) tick();
    en_sync_in = 1'b1; vin_valid = 1'b0;
    tick();
    chk("abort_no_pulse", pulses, p0);
    for (int k = 0; k < NCH; k++) begin
      vals[k] = 32 * k; exp_sg[k] = 1; exp_mg[k] = 2 * k;
    end
    send_frame(NCH, 0, -1, e1);
    vin_valid = 1'b0;
    wait_pulse(p0 + 1);
    if (pulse_cyc.size() >= p0 + 1)
      chk("abort_latency", pulse_cyc[p0], e1 + 2);
    check_frame("abort", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
